// File: rtl/root_node_pkg.sv
// Shared constants and the buffered word type for the root-node fan-in collector.
package root_node_pkg;

    localparam int DEF_NUM_CHILD = 5;
    localparam int DEF_DATA_W    = 16;
    localparam int IDX_W         = 3;

    typedef struct packed {
        logic [IDX_W-1:0]      idx;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/root_node_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module root_node_rr_arbiter
    import root_node_pkg::*;
#(
    parameter int NUM_CHILD = DEF_NUM_CHILD
) (
    input  logic [NUM_CHILD-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_CHILD-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx
);

    int   w_cand;
    logic w_found;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            w_cand = (int'(i_ptr) + k) % NUM_CHILD;
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/root_node_fanin_collector.sv
// Collects words from NUM_CHILD child ports round-robin into a 2-entry FIFO toward the parent.
module root_node_fanin_collector
    import root_node_pkg::*;
#(
    parameter int NUM_CHILD = DEF_NUM_CHILD,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic [DATA_W-1:0]           out_data,
    output logic [15:0]                 fwd_count
);

    fifo_entry_t          r_fifo [2];
    logic [1:0]           r_count;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [15:0]          r_fwd_count;

    logic [NUM_CHILD-1:0] w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    fifo_entry_t          w_new;

    root_node_rr_arbiter #(
        .NUM_CHILD (NUM_CHILD)
    ) u_arb (
        .i_req   (child_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx)
    );

    // A full buffer blocks every child, even when the parent drains this cycle.
    assign w_full      = (r_count == 2'd2);
    assign child_ready = (rst || w_full) ? '0 : w_grant;
    assign w_push      = |child_ready;
    assign w_pop       = out_valid && out_ready;

    assign w_new.idx  = w_grant_idx;
    assign w_new.data = DEF_DATA_W'(child_data[int'(w_grant_idx)*DATA_W +: DATA_W]);

    assign out_valid = (r_count != 2'd0);
    assign out_idx   = r_fifo[0].idx;
    assign out_data  = DATA_W'(r_fifo[0].data);
    assign fwd_count = r_fwd_count;

    // NOTE: the FIFO storage is reset too, because out_idx/out_data must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 2'd0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    r_fifo[r_count[0]] <= w_new;
                    r_count            <= r_count + 2'd1;
                end
                2'b01: begin
                    r_fifo[0] <= r_fifo[1];
                    r_count   <= r_count - 2'd1;
                end
                2'b11:   r_fifo[0] <= w_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_fwd_count <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (int'(w_grant_idx) == NUM_CHILD - 1) ? '0 : w_grant_idx + 1'b1;
            if (r_fwd_count != 16'hFFFF) begin
                r_fwd_count <= r_fwd_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_root_node_fanin_collector.sv
// Scoreboard bench for the fan-in collector: reference model predicts grants and words, monitor checks pops.
module tb_root_node_fanin_collector;

    localparam int N = 5;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   child_valid = '0;
    logic [N*W-1:0] child_data = '0;
    logic [N-1:0]   child_ready;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2:0]     out_idx;
    logic [W-1:0]   out_data;
    logic [15:0]    fwd_count;

    root_node_fanin_collector #(
        .NUM_CHILD (N),
        .DATA_W    (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_data    (out_data),
        .fwd_count   (fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
    } word_t;

    word_t      exp_q[$];
    word_t      mon_e;
    int         n_cmp = 0;
    int         n_mis = 0;
    int         m_ptr = 0;
    int         m_occ = 0;
    int         m_fwd = 0;
    bit         stall_prev = 0;
    logic [2:0] prev_idx;
    logic [W-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scan children starting at the pointer, first valid one wins if the buffer has room.
    task automatic model_cycle();
        int           g = -1;
        logic [N-1:0] exp_rdy = '0;
        bit           pop;
        if (m_occ < 2) begin
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (g < 0 && child_valid[c]) g = c;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("child_ready", child_ready, exp_rdy);
        check("out_valid", out_valid, m_occ > 0);
        check("fwd_count", fwd_count, m_fwd);
        if (stall_prev) begin
            check("hold_idx", out_idx, prev_idx);
            check("hold_data", out_data, prev_data);
        end
        stall_prev = out_valid && !out_ready;
        prev_idx   = out_idx;
        prev_data  = out_data;
        pop = (m_occ > 0) && out_ready;
        if (g >= 0) begin
            exp_q.push_back('{g, int'(child_data[g*W +: W])});
            m_ptr = (g + 1) % N;
            if (m_fwd < 65535) m_fwd++;
        end
        m_occ = m_occ + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        child_valid = v;
        out_ready   = r;
        for (int i = 0; i < N; i++) child_data[i*W +: W] = W'($urandom);
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [N-1:0] v, input logic r);
        drive(v, r);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_child_ready", child_ready, 0);
        check("rst_fwd_count", fwd_count, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_data", out_data, 0);
        exp_q.delete();
        m_ptr = 0;
        m_occ = 0;
        m_fwd = 0;
        stall_prev = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every parent-side transfer must match the oldest predicted word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {31'b0, out_valid}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_idx", out_idx, mon_e.idx);
                    check("out_data", out_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        child_valid = '1;
        @(posedge clk);
        #1;
        do_reset();

        // Continuous requests from every child: indices 0,1,2,3,4,0.
        repeat (6) cyc(5'b11111, 1'b1);
        repeat (3) cyc(5'b00000, 1'b1);
        check("six_accepts_fwd", fwd_count, 6);

        // Pointer is 1 here; child 3 alone gets granted and sets the pointer to 4.
        drive(5'b01000, 1'b1);
        child_data[3*W +: W] = 16'h00A5;
        #1;
        check("lone_child3_ready", child_ready, 5'b01000);
        tick();
        check("lone_child3_valid", out_valid, 1);
        check("lone_child3_idx", out_idx, 3);
        check("lone_child3_data", out_data, 16'h00A5);
        cyc(5'b00000, 1'b1);

        // Wrap: with the pointer at 4, child 4 wins before child 0.
        drive(5'b10001, 1'b1);
        #1;
        check("wrap_first_grant", child_ready, 5'b10000);
        tick();
        drive(5'b10001, 1'b1);
        #1;
        check("wrap_second_grant", child_ready, 5'b00001);
        tick();
        repeat (3) cyc(5'b00000, 1'b1);

        // Backpressure: two words fill the buffer, the third request is blocked.
        repeat (2) cyc(5'b00110, 1'b0);
        drive(5'b00110, 1'b1);
        #1;
        check("full_blocks_ready", child_ready, 0);
        tick();
        repeat (4) cyc(5'b00000, 1'b1);

        // Randomised traffic with occasional parent stalls.
        for (int i = 0; i < 1500; i++) begin
            cyc(N'($urandom_range(0, 31)), ($urandom % 4) != 0);
        end
        repeat (4) cyc(5'b00000, 1'b1);
        check("queue_drained", exp_q.size(), 0);

        // Reset with two entries held: outputs clear without waiting for a clock edge.
        cyc(5'b00011, 1'b0);
        cyc(5'b00011, 1'b0);
        check("prefill_occupied", out_valid, 1);
        do_reset();
        drive(5'b00100, 1'b1);
        tick();
        check("post_reset_idx", out_idx, 2);
        check("post_reset_valid", out_valid, 1);
        cyc(5'b00000, 1'b1);

        // Saturate the forwarded-word counter.
        repeat (65545) cyc(5'b11111, 1'b1);
        check("fwd_saturated", fwd_count, 16'hFFFF);
        repeat (3) cyc(5'b00000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/root_node_fanin_collector.md
ROOT_NODE_FANIN_COLLECTOR -- requirements
Module: root_node_fanin_collector

Interface
REQ-001 SHALL have parameter NUM_CHILD, default 5, number of child ports collected.
REQ-002 SHALL have parameter DATA_W, default 16, child payload width.
REQ-003 SHALL have port clk input 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port child_valid input NUM_CHILD: per-child word valid.
REQ-006 SHALL have port child_data input NUM_CHILD*DATA_W: per-child payload, child i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port child_ready output NUM_CHILD: per-child accept; at most one bit high per cycle.
REQ-008 SHALL have port out_valid output 1: parent-side word available.
REQ-009 SHALL have port out_ready input 1: parent accepts word.
REQ-010 SHALL have port out_idx output 3: index of the source child of out_data.
REQ-011 SHALL have port out_data output DATA_W: forwarded payload.
REQ-012 SHALL have port fwd_count output 16: total words accepted from children since reset.

Function
REQ-013 SHALL transfer a child word only when child_valid[i] and child_ready[i] are both high on a clock edge; likewise parent transfer on out_valid and out_ready.
REQ-014 SHALL arbitrate round-robin: grant the lowest index >= rr_ptr with child_valid high, wrapping past NUM_CHILD-1 to 0.
REQ-015 SHALL assert child_ready only for the granted child and only when the output buffer is not full; child_ready is combinational from child_valid, rr_ptr and buffer occupancy.
REQ-016 SHALL update rr_ptr to (granted index + 1) mod NUM_CHILD only on an accepted transfer; index 4 wraps to 0; no accept leaves rr_ptr unchanged.
REQ-017 SHALL buffer accepted words in a 2-entry FIFO of {idx, data}; out_valid high whenever occupancy > 0; out_idx/out_data show the oldest entry.
REQ-018 SHALL present an accepted word on the output no earlier than the cycle after acceptance (1-cycle latency when empty).
REQ-019 SHALL, with occupancy 1, allow simultaneous push and pop with occupancy staying 1 and order preserved.
REQ-020 SHALL, with occupancy 2, deassert all child_ready even if out_ready is high that cycle (no push-on-full).
REQ-021 SHALL hold out_idx/out_data stable while out_valid high and out_ready low.
REQ-022 SHALL increment fwd_count on each child accept, saturating at 16'hFFFF.
REQ-023 SHALL ignore child_data of non-granted children entirely.

Reset
REQ-024 SHALL on rst high, asynchronously clear FIFO occupancy, rr_ptr to 0, fwd_count to 0; out_valid 0, child_ready 0, out_idx 0, out_data 0.
REQ-025 SHALL discard buffered words when reset asserts mid-operation; first grant after release uses rr_ptr 0.

Structure
REQ-026 SHALL place NUM_CHILD default, DATA_W default, IDX_W=3 and typedef of the {idx, data} FIFO entry in shared package root_node_pkg.
REQ-027 SHALL implement arbitration in one sub-module root_node_rr_arbiter (request vector, pointer, accept in; one-hot grant and index out); FIFO and counter stay in the top.

Verification
REQ-028 All five child_valid high continuously, out_ready 1 -> out_idx sequence 0,1,2,3,4,0 with one word accepted per cycle, fwd_count 6 after six accepts.
REQ-029 Only child 3 valid with data 16'h00A5, buffer empty -> child_ready=5'b01000, next cycle out_valid 1, out_idx 3, out_data 16'h00A5, rr_ptr 4.
REQ-030 out_ready 0, children 1 and 2 valid -> two words buffered, third cycle child_ready 0; raise out_ready -> words pop in order idx 1 then 2.
REQ-031 rr_ptr 4, children 0 and 4 valid -> child 4 granted first, then child 0 (wrap check).
REQ-032 Preload fwd_count near 16'hFFFF via 65535 accepts, then 3 more -> fwd_count stays 16'hFFFF.
REQ-033 Assert rst with 2 entries buffered -> out_valid 0 immediately (asynchronous), fwd_count 0; after release child 2 alone valid -> out_idx 2.
